ldm_sequencer: RTL and testbench

- Multi-cycle sequencer for ARM LDM (load multiple); sits directly upstream of the register file write port.
- Accepts one decoded LDM command and issues one memory read per listed register, lowest register first.
- Writes each loaded word into the register file through the rd/pc write ports, then optionally writes back the updated base register.
- Only one memory request is outstanding at a time.

---
 rtl/ldm_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ldm_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_sequencer.sv
// LDM load-multiple sequencer: one memory read per listed register, lowest first,
// feeding the register file / PC write ports, with optional base writeback.
module ldm_sequencer #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [NUM_REGS-1:0]   cmd_reglist,
  input  logic [WORD_SIZE-1:0]  cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_base_reg,
  input  logic                  cmd_up,
  input  logic                  cmd_pre,
  input  logic                  cmd_wb,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [WORD_SIZE-1:0]  mem_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_SIZE-1:0]  mem_rsp_data,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, WB, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(15);

  state_t                  state_q, state_d;
  logic [NUM_REGS-1:0]     list_q, list_d;
  logic [WORD_SIZE-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0]    data_q, data_d;
  logic [WORD_SIZE-1:0]    wbval_q, wbval_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   base_reg_q, base_reg_d;
  logic                    wb_q, wb_d;

  logic [WORD_SIZE-1:0]    nbytes;
  logic [WORD_SIZE-1:0]    start_addr;
  logic [ADDR_WIDTH-1:0]   low_idx;

  // Byte span of the transfer (4 * popcount) and the lowest pending register.
  always_comb begin
    nbytes = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      nbytes = nbytes + WORD_SIZE'(cmd_reglist[i]);
    end
    nbytes = nbytes << 2;
    low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (list_q[i]) low_idx = ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    case ({cmd_up, cmd_pre})
      2'b10:   start_addr = cmd_base;
      2'b11:   start_addr = cmd_base + WORD_SIZE'(4);
      2'b00:   start_addr = cmd_base - nbytes + WORD_SIZE'(4);
      default: start_addr = cmd_base - nbytes;
    endcase
    start_addr[1:0] = 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      list_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wbval_q    <= '0;
      idx_q      <= '0;
      base_reg_q <= '0;
      wb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wbval_q    <= wbval_d;
      idx_q      <= idx_d;
      base_reg_q <= base_reg_d;
      wb_q       <= wb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    list_d        = list_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wbval_d       = wbval_q;
    idx_d         = idx_q;
    base_reg_d    = base_reg_q;
    wb_d          = wb_q;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    rd_we         = 1'b0;
    write_rd      = '0;
    rd_in         = '0;
    pc_we         = 1'b0;
    pc_in         = '0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          list_d     = cmd_reglist;
          base_reg_d = cmd_base_reg;
          addr_d     = start_addr;
          wbval_d    = cmd_up ? (cmd_base + nbytes) : (cmd_base - nbytes);
          // A base register that is also loaded keeps the loaded value.
          wb_d       = cmd_wb & ~cmd_reglist[cmd_base_reg] & (cmd_base_reg != PC_IDX);
          state_d    = (cmd_reglist == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = addr_q;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          data_d          = mem_rsp_data;
          idx_d           = low_idx;
          list_d[low_idx] = 1'b0;
          state_d         = WRITE;
        end
      end
      WRITE: begin
        if (idx_q == PC_IDX) begin
          pc_we = 1'b1;
          pc_in = {data_q[WORD_SIZE-1:2], 2'b00};
        end else begin
          rd_we    = 1'b1;
          write_rd = idx_q;
          rd_in    = data_q;
        end
        if (list_q != '0) begin
          addr_d  = addr_q + WORD_SIZE'(4);
          state_d = REQ;
        end else begin
          state_d = wb_q ? WB : DONE;
        end
      end
      WB: begin
        rd_we    = 1'b1;
        write_rd = base_reg_q;
        rd_in    = wbval_q;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_sequencer.sv
// Directed bench for ldm_sequencer: drives LDM commands and a hand-scripted memory,
// checking addresses, register/PC writes, writeback, done and reset behaviour.
module tb_ldm_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_reglist;
  logic [31:0] cmd_base;
  logic [3:0]  cmd_base_reg;
  logic        cmd_up;
  logic        cmd_pre;
  logic        cmd_wb;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rd_we;
  logic [3:0]  write_rd;
  logic [31:0] rd_in;
  logic        pc_we;
  logic [31:0] pc_in;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  ldm_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_reglist   (cmd_reglist),
    .cmd_base      (cmd_base),
    .cmd_base_reg  (cmd_base_reg),
    .cmd_up        (cmd_up),
    .cmd_pre       (cmd_pre),
    .cmd_wb        (cmd_wb),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rd_we         (rd_we),
    .write_rd      (write_rd),
    .rd_in         (rd_in),
    .pc_we         (pc_we),
    .pc_in         (pc_in),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_req"},   32'(mem_req_valid), 32'd0);
    check_eq({tag, "_addr"},  mem_addr, 32'd0);
    check_eq({tag, "_rdwe"},  32'(rd_we), 32'd0);
    check_eq({tag, "_wrd"},   32'(write_rd), 32'd0);
    check_eq({tag, "_rdin"},  rd_in, 32'd0);
    check_eq({tag, "_pcwe"},  32'(pc_we), 32'd0);
    check_eq({tag, "_pcin"},  pc_in, 32'd0);
    check_eq({tag, "_done"},  32'(done), 32'd0);
  endtask

  // Offer a command at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [15:0] rl, input logic [31:0] base, input logic [3:0] breg,
                       input logic up, input logic pre, input logic wb);
    check_eq("issue_ready", 32'(cmd_ready), 32'd1);
    cmd_reglist  = rl;
    cmd_base     = base;
    cmd_base_reg = breg;
    cmd_up       = up;
    cmd_pre      = pre;
    cmd_wb       = wb;
    cmd_valid    = 1'b1;
    step();
    cmd_valid    = 1'b0;
    check_eq("issue_busy", 32'(busy), 32'd1);
    check_eq("issue_notready", 32'(cmd_ready), 32'd0);
  endtask

  // Serve one read; returns at the negedge where the DUT sits in WRITE.
  task automatic serve(input logic [31:0] exp_addr, input logic [31:0] data,
                       input int stall, input bit stray);
    int t = 0;
    while (!mem_req_valid && t < 20) begin
      step();
      t++;
    end
    check_eq("req_seen", 32'(mem_req_valid), 32'd1);
    check_eq("req_addr", mem_addr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      if (stray) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
      end
      step();
      check_eq("stall_req", 32'(mem_req_valid), 32'd1);
      check_eq("stall_addr", mem_addr, exp_addr);
      check_eq("stall_nowrite", 32'(rd_we | pc_we), 32'd0);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check_eq("wait_noreq", 32'(mem_req_valid), 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
  endtask

  task automatic expect_rd(input logic [3:0] idx, input logic [31:0] data);
    check_eq("rd_we", 32'(rd_we), 32'd1);
    check_eq("pc_we_off", 32'(pc_we), 32'd0);
    check_eq("write_rd", 32'(write_rd), 32'(idx));
    check_eq("rd_in", rd_in, data);
  endtask

  task automatic expect_pc(input logic [31:0] data);
    check_eq("pc_we", 32'(pc_we), 32'd1);
    check_eq("rd_we_off", 32'(rd_we), 32'd0);
    check_eq("pc_in", pc_in, data);
  endtask

  task automatic expect_done(input string tag);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_nowr"}, 32'(rd_we | pc_we), 32'd0);
    step();
    check_eq({tag, "_done_clr"}, 32'(done), 32'd0);
    check_eq({tag, "_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_reglist   = '0;
    cmd_base      = '0;
    cmd_base_reg  = '0;
    cmd_up        = 1'b0;
    cmd_pre       = 1'b0;
    cmd_wb        = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    #2;
    check_idle_outputs("rst");
    step();
    step();
    reset = 1'b0;
    step();

    // LDMIA r0!, {r1,r2}
    issue(16'h0006, 32'h100, 4'd0, 1'b1, 1'b0, 1'b1);
    serve(32'h100, 32'hA, 0, 1'b0);
    expect_rd(4'd1, 32'hA);
    step();
    serve(32'h104, 32'hB, 0, 1'b0);
    expect_rd(4'd2, 32'hB);
    step();
    expect_rd(4'd0, 32'h108);
    step();
    expect_done("ia");
    $display("txn LDMIA base=0x100 list=0x0006 complete");

    // LDMDB r13, {r0,r15}
    issue(16'h8001, 32'h200, 4'd13, 1'b0, 1'b1, 1'b0);
    serve(32'h1F8, 32'h11, 0, 1'b0);
    expect_rd(4'd0, 32'h11);
    step();
    serve(32'h1FC, 32'h2003, 0, 1'b0);
    expect_pc(32'h2000);
    step();
    expect_done("db");
    $display("txn LDMDB base=0x200 list=0x8001 complete");

    // LDMIB r3!, {r3}: loaded value wins, no writeback cycle
    issue(16'h0008, 32'h40, 4'd3, 1'b1, 1'b1, 1'b1);
    serve(32'h44, 32'h77, 0, 1'b0);
    expect_rd(4'd3, 32'h77);
    step();
    expect_done("ib");
    $display("txn LDMIB base=0x40 list=0x0008 complete");

    // LDMDA r5!, {r0,r1} with base 4: start address 0, writeback wraps
    issue(16'h0003, 32'h4, 4'd5, 1'b0, 1'b0, 1'b1);
    serve(32'h0, 32'h1, 0, 1'b0);
    expect_rd(4'd0, 32'h1);
    step();
    serve(32'h4, 32'h2, 0, 1'b0);
    expect_rd(4'd1, 32'h2);
    step();
    expect_rd(4'd5, 32'hFFFF_FFFC);
    step();
    expect_done("da");
    $display("txn LDMDA base=0x4 list=0x0003 complete");

    // Empty list: straight to DONE, no memory traffic
    issue(16'h0000, 32'h80, 4'd2, 1'b1, 1'b0, 1'b1);
    check_eq("empty_noreq", 32'(mem_req_valid), 32'd0);
    expect_done("empty");
    $display("txn empty list complete");

    // Stalled request with stray responses while in REQ
    issue(16'h0010, 32'h300, 4'd1, 1'b1, 1'b0, 1'b0);
    serve(32'h300, 32'h55AA, 5, 1'b1);
    expect_rd(4'd4, 32'h55AA);
    step();
    expect_done("stall");
    $display("txn stalled LDMIA base=0x300 complete");

    // Reset while waiting on the first response of a 4-register LDMIA
    issue(16'h00F0, 32'h500, 4'd0, 1'b1, 1'b0, 1'b1);
    check_eq("rst_req", 32'(mem_req_valid), 32'd1);
    check_eq("rst_req_addr", mem_addr, 32'h500);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    reset         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD;
    #1;
    check_idle_outputs("midrst");
    step();
    check_idle_outputs("midrst_hold");
    reset         = 1'b0;
    step();
    mem_rsp_valid = 1'b0;
    check_idle_outputs("postrst");
    step();
    issue(16'h0002, 32'h600, 4'd0, 1'b1, 1'b0, 1'b0);
    serve(32'h600, 32'h99, 0, 1'b0);
    expect_rd(4'd1, 32'h99);
    step();
    expect_done("after_rst");
    $display("txn post-reset LDMIA base=0x600 complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
